// File: rtl/au_seq_pkg.sv
// Shared opcode constants, FSM state encoding and default operand width for the AU sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package au_seq_pkg;

  // Default operand width; results are twice this wide.
  localparam int SEQ_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NEG = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/au_seq_alu.sv
// Combinational ALU on 2*WIDTH-bit operands: ADD/SUB/AND/OR/XOR/NEG plus WIDTH-bit signed overflow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the sequencer decides when the outputs are sampled.
import au_seq_pkg::*;

module au_seq_alu #(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic [2:0]         op,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  output logic [2*WIDTH-1:0] y,
  output logic               ovf
);

  // Operands arrive sign-extended from WIDTH bits, so the exact ADD/SUB/NEG
  // result is available here; overflow means it does not fit back into WIDTH
  // signed bits (upper bits plus the narrow sign bit are not all equal).
  logic [WIDTH:0] top_bits;

  // Operation select and overflow detection.
  always_comb begin
    y   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NEG:  y = '0 - a;
      default: y = '0;
    endcase
    top_bits = y[2*WIDTH-1:WIDTH-1];
    if (op == OP_ADD || op == OP_SUB || op == OP_NEG) begin
      ovf = !((&top_bits) || (~|top_bits));
    end
  end

endmodule

// File: rtl/au_op_sequencer.sv
// Arithmetic sequencer: single-command ALU ops and a WIDTH-step shift-add signed multiplier.
// Latency: out_valid 2 edges after acceptance for ALU ops/reserved, WIDTH+1 edges for MUL.
// Backpressure: result held in DONE until out_ready; no new command accepted until back in IDLE.
import au_seq_pkg::*;

module au_op_sequencer #(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf,
  output logic               zero,
  output logic               neg,
  output logic               err,
  output logic               busy
);

  localparam int              CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

  seq_state_t         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               sgn_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_s;
  logic               err_s;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2:0]         alu_op;
  logic [2*WIDTH-1:0] alu_a;
  logic [2*WIDTH-1:0] alu_b;
  logic [2*WIDTH-1:0] alu_y;
  logic               alu_ovf;
  logic [2*WIDTH-1:0] exec_val;
  logic [2*WIDTH-1:0] commit_res;
  logic               commit_ovf;
  logic               commit_err;

  // Operand magnitudes for the multiplier; |-2^(WIDTH-1)| still fits as unsigned WIDTH bits.
  always_comb begin
    a_mag = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
  end

  // ALU input steering: captured operands in EXEC, accumulator add while
  // iterating MUL, and accumulator negation on the final MUL cycle.
  always_comb begin
    alu_op = OP_ADD;
    alu_a  = acc;
    alu_b  = mcand;
    if (state == EXEC) begin
      alu_op = op_q;
      alu_a  = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      alu_b  = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else if (state == MUL && cnt == CNT_DONE) begin
      alu_op = OP_NEG;
      alu_a  = acc;
      alu_b  = '0;
    end
  end

  au_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .op  (alu_op),
    .a   (alu_a),
    .b   (alu_b),
    .y   (alu_y),
    .ovf (alu_ovf)
  );

  // EXEC staging value: narrow ops wrap to WIDTH bits then sign-extend,
  // NEG keeps the exact value (so -(-128) reads back as +128), reserved gives 0.
  always_comb begin
    exec_val = '0;
    case (op_q)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
        exec_val = {{WIDTH{alu_y[WIDTH-1]}}, alu_y[WIDTH-1:0]};
      OP_NEG:
        exec_val = alu_y;
      default:
        exec_val = '0;
    endcase
  end

  // Value and flags loaded into the output registers on entry to DONE.
  always_comb begin
    commit_res = acc;
    commit_ovf = 1'b0;
    commit_err = 1'b0;
    if (state == MUL) begin
      commit_res = sgn_q ? alu_y : acc;
    end else begin
      commit_ovf = ovf_s;
      commit_err = err_s;
    end
  end

  // Sequencer FSM with registered handshake, status and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      ovf_s     <= 1'b0;
      err_s     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q     <= op;
            a_q      <= a;
            b_q      <= b;
            sgn_q    <= a[WIDTH-1] ^ b[WIDTH-1];
            mcand    <= {{WIDTH{1'b0}}, a_mag};
            mplier   <= b_mag;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= (op == OP_MUL) ? MUL : EXEC;
          end
        end
        EXEC: begin
          // First cycle stages the ALU result; second cycle commits it,
          // mirroring the MUL path which also commits from the accumulator.
          if (cnt == '0) begin
            acc   <= exec_val;
            ovf_s <= alu_ovf;
            err_s <= (op_q == OP_RSV);
            cnt   <= CNT_W'(1);
          end else begin
            result    <= commit_res;
            ovf       <= commit_ovf;
            err       <= commit_err;
            zero      <= (commit_res == '0);
            neg       <= commit_res[2*WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        MUL: begin
          if (cnt != CNT_DONE) begin
            if (mplier[0]) begin
              acc <= alu_y;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
          end else begin
            result    <= commit_res;
            ovf       <= commit_ovf;
            err       <= commit_err;
            zero      <= (commit_res == '0);
            neg       <= commit_res[2*WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_au_op_sequencer.sv
// Directed bench for au_op_sequencer: hand-computed vectors checked with immediate assertions.
// Latency: measures edges from acceptance to out_valid for each command.
// Backpressure: exercises out_ready held low while a new command waits.
module tb_au_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf;
  logic        zero;
  logic        neg;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

  au_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg),
    .err       (err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command in IDLE, take the acceptance edge, scramble the inputs,
  // then count edges until out_valid (bounded at 20).
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int l);
    in_valid = 1'b1;
    op       = o;
    a        = x;
    b        = y;
    tick();
    in_valid = 1'b0;
    op       = 3'b100;
    a        = 8'h5A;
    b        = 8'hC3;
    l = 0;
    while (!out_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  // Consume the result (out_ready held high) and return to IDLE.
  task automatic retire(input string tag);
    tick();
    check({tag, ".in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op        = 3'b000;
    a         = 8'h00;
    b         = 8'h00;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst.result",    {16'd0, result}, 32'h0000);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.busy",      {31'd0, busy}, 32'd0);
    check("rst.in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst.flags",     {28'd0, ovf, zero, neg, err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // ADD 100+27 = 127
    issue(3'b000, 8'd100, 8'd27, lat);
    check("add127.lat",    lat, 32'd2);
    check("add127.result", {16'd0, result}, 32'h007F);
    check("add127.flags",  {28'd0, ovf, zero, neg, err}, 32'h0);
    check("add127.busy",   {31'd0, busy}, 32'd1);
    retire("add127");
    check("add127.idle_busy", {31'd0, busy}, 32'd0);

    // ADD 100+28 wraps to -128
    issue(3'b000, 8'd100, 8'd28, lat);
    check("add128.result", {16'd0, result}, 32'hFF80);
    check("add128.flags",  {28'd0, ovf, zero, neg, err}, 32'b1010);
    retire("add128");

    // SUB -128-1 wraps to 127
    issue(3'b001, 8'h80, 8'h01, lat);
    check("sub.result", {16'd0, result}, 32'h007F);
    check("sub.flags",  {28'd0, ovf, zero, neg, err}, 32'b1000);
    retire("sub");

    // Logic ops, sign-extended from bit 7
    issue(3'b010, 8'hF0, 8'h3C, lat);
    check("and.result", {16'd0, result}, 32'h0030);
    retire("and");
    issue(3'b011, 8'h80, 8'h01, lat);
    check("or.result", {16'd0, result}, 32'hFF81);
    check("or.flags",  {28'd0, ovf, zero, neg, err}, 32'b0010);
    retire("or");
    issue(3'b100, 8'h0F, 8'hFF, lat);
    check("xor.result", {16'd0, result}, 32'hFFF0);
    retire("xor");

    // MUL -128*-128 = 16384
    issue(3'b110, 8'h80, 8'h80, lat);
    check("mulmax.lat",    lat, 32'd9);
    check("mulmax.result", {16'd0, result}, 32'h4000);
    check("mulmax.flags",  {28'd0, ovf, zero, neg, err}, 32'h0);
    retire("mulmax");

    // MUL -7*9 = -63
    issue(3'b110, 8'hF9, 8'h09, lat);
    check("mulneg.lat",    lat, 32'd9);
    check("mulneg.result", {16'd0, result}, 32'hFFC1);
    check("mulneg.flags",  {28'd0, ovf, zero, neg, err}, 32'b0010);
    retire("mulneg");

    // MUL 0*-5 = 0
    issue(3'b110, 8'h00, 8'hFB, lat);
    check("mulzero.result", {16'd0, result}, 32'h0000);
    check("mulzero.flags",  {28'd0, ovf, zero, neg, err}, 32'b0100);
    retire("mulzero");

    // Reserved opcode
    issue(3'b111, 8'h05, 8'h03, lat);
    check("rsv.lat",    lat, 32'd2);
    check("rsv.result", {16'd0, result}, 32'h0000);
    check("rsv.flags",  {28'd0, ovf, zero, neg, err}, 32'b0101);
    retire("rsv");

    // NEG -128 -> +128 exact, overflow; NEG 5 -> -5
    issue(3'b101, 8'h80, 8'h00, lat);
    check("neg128.result", {16'd0, result}, 32'h0080);
    check("neg128.flags",  {28'd0, ovf, zero, neg, err}, 32'b1000);
    retire("neg128");
    issue(3'b101, 8'h05, 8'h00, lat);
    check("neg5.result", {16'd0, result}, 32'hFFFB);
    check("neg5.flags",  {28'd0, ovf, zero, neg, err}, 32'b0010);
    retire("neg5");

    // Backpressure: hold result while a new command waits
    out_ready = 1'b0;
    issue(3'b000, 8'd3, 8'd4, lat);
    check("bp.lat",    lat, 32'd2);
    check("bp.result", {16'd0, result}, 32'h0007);
    in_valid = 1'b1;
    op       = 3'b000;
    a        = 8'd10;
    b        = 8'd20;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp.hold_valid",  {31'd0, out_valid}, 32'd1);
      check("bp.hold_result", {16'd0, result}, 32'h0007);
      check("bp.hold_ready",  {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp.release_valid", {31'd0, out_valid}, 32'd0);
    check("bp.release_ready", {31'd0, in_ready}, 32'd1);
    check("bp.release_busy",  {31'd0, busy}, 32'd0);
    issue(3'b000, 8'd10, 8'd20, lat);
    check("bp.next_lat",    lat, 32'd2);
    check("bp.next_result", {16'd0, result}, 32'h001E);
    retire("bp");

    // Reset in the middle of a MUL
    in_valid = 1'b1;
    op       = 3'b110;
    a        = 8'hF9;
    b        = 8'h09;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mrst.no_valid_before", {31'd0, out_valid}, 32'd0);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst.result",   {16'd0, result}, 32'h0000);
    check("mrst.busy",     {31'd0, busy}, 32'd0);
    check("mrst.in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst.flags",    {28'd0, ovf, zero, neg, err}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mrst.no_valid_after", {31'd0, out_valid}, 32'd0);
    end
    issue(3'b000, 8'd1, 8'd1, lat);
    check("mrst.add_lat",    lat, 32'd2);
    check("mrst.add_result", {16'd0, result}, 32'h0002);
    retire("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
